// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator for a word-addressed registered data memory
module lsu_mem_master #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, RD, LCAP, MERGE, WR, ERR} state_t;
  state_t state, state_nx;
  logic we_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wbuf;
  logic legal, misal, oor, bad;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, mask, ins, merged;
  always_comb begin
    legal = we_i ? (funct3_i <= 3'd2) : (funct3_i != 3'd3 && funct3_i[2:1] != 2'b11);
    misal = funct3_i[1:0] == 2'b01 ? addr_i[0] : funct3_i[1:0] == 2'b10 ? |addr_i[1:0] : 1'b0;
    oor = {2'b00, addr_i[31:2]} >= 32'(MEM_WORDS);
    bad = !legal || misal || oor;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !req_i ? IDLE : bad ? ERR : (we_i && funct3_i == 3'd2) ? WR : RD;
      RD:      state_nx = we_q ? MERGE : LCAP;
      MERGE:   state_nx = WR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    byte_sel = 8'(mem_rdata_i >> {addr_q[1:0], 3'b000});
    half_sel = 16'(mem_rdata_i >> {addr_q[1], 4'b0000});
    load_val = f3_q[1] ? mem_rdata_i
             : f3_q[0] ? {{16{!f3_q[2] && half_sel[15]}}, half_sel}
             : {{24{!f3_q[2] && byte_sel[7]}}, byte_sel};
    mask = f3_q[0] ? 32'h0000_ffff << {addr_q[1], 4'b0000} : 32'h0000_00ff << {addr_q[1:0], 3'b000};
    ins = f3_q[0] ? {2{wbuf[15:0]}} : {4{wbuf[7:0]}};
    merged = (mem_rdata_i & ~mask) | (ins & mask);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q <= 1'b0;
      f3_q <= 3'd0;
      addr_q <= '0;
      wbuf <= '0;
      rdata_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (state == IDLE && req_i) begin
        we_q <= we_i;
        f3_q <= funct3_i;
        addr_q <= addr_i;
        wbuf <= wdata_i;
      end
      if (state == MERGE) wbuf <= merged;
      if (state == LCAP) rdata_o <= load_val;
      done_o <= state == LCAP || state == WR || state == ERR;
      err_o <= state == ERR;
    end
  end
  assign busy_o = state != IDLE;
  assign mem_rd_o = state == RD;
  assign mem_wr_o = state == WR;
  assign mem_addr_o = (busy_o && state != ERR) ? {2'b00, addr_q[31:2]} : '0;
  assign mem_wdata_o = mem_wr_o ? wbuf : '0;
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator sitting between the nano_rv32i execute stage and the word-addressed, single-cycle-registered data memory. It translates RV32I byte/halfword/word loads and stores into the memory's `rd_i`/`wr_i` word protocol. It performs lane selection, sign/zero extension, and read-modify-write for sub-word stores. It also checks alignment and range, and reports completion with a one-cycle `done_o` pulse.

## Interface

**Parameters**
- `MEM_WORDS`, default 256: number of 32-bit words in the attached memory. Word indices at or above this value are out of range.

**Ports**
- `clk_i`, input, 1: single clock, rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `req_i`, input, 1: access request. Sampled only in IDLE.
- `we_i`, input, 1: 1 = store, 0 = load.
- `funct3_i`, input, 3: RV32I width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `addr_i`, input, 32: byte address.
- `wdata_i`, input, 32: store data, right-aligned.
- `busy_o`, output, 1: high whenever the FSM is not in IDLE.
- `done_o`, output, 1: one-cycle completion pulse.
- `err_o`, output, 1: valid with `done_o`. Signals misaligned address, illegal funct3, or out of range.
- `rdata_o`, output, 32: load result. Held until the next successful load.
- `mem_addr_o`, output, 32: word index = `addr_i[31:2]`, zero-extended.
- `mem_rd_o`, output, 1: memory read strobe.
- `mem_wr_o`, output, 1: memory write strobe.
- `mem_wdata_o`, output, 32: memory write data.
- `mem_rdata_i`, input, 32: memory read data. Valid the cycle after `mem_rd_o` was high.

## Operation

**Request capture**
- In IDLE, when `req_i` is high, latch `we_i`, `funct3_i`, `addr_i` and `wdata_i`. Inputs are ignored while busy.

**Error check** (done at capture)
- LH/LHU/SH with `addr[0]`=1 is an error.
- LW/SW with `addr[1:0]`≠0 is an error.
- Illegal funct3 is an error: 011, 110, 111 for loads; anything above 010 for stores.
- `addr[31:2]` ≥ `MEM_WORDS` is an error.
- On error: go to ERR. No memory strobe is issued. `rdata_o` is unchanged.

**FSM states:** IDLE, RD, LCAP, MERGE, WR, ERR.
- Load: IDLE → RD → LCAP → IDLE.
- SW: IDLE → WR → IDLE.
- SB/SH: IDLE → RD → MERGE → WR → IDLE.
- Error: IDLE → ERR → IDLE.

**Strobes and address**
- `mem_rd_o` = (state==RD). `mem_wr_o` = (state==WR). Never both high.
- `mem_addr_o` holds the latched word index during RD, LCAP, MERGE and WR. It is 0 in IDLE.

**Byte lanes**
- Little-endian: byte k = bits [8k+7:8k], k = `addr[1:0]`. Halfword uses lanes `addr[1]`*2 and `addr[1]`*2+1.

**Loads (LCAP)**
- Select the lane from `mem_rdata_i`.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Register the result into `rdata_o`.

**Sub-word stores (MERGE)**
- Replace only the target lane(s) of `mem_rdata_i` with `wdata_i[7:0]` or `wdata_i[15:0]`.
- Register the result into the write buffer. All other bytes stay unchanged.
- SW writes `wdata_i` directly.

**`mem_wdata_o`** equals the write buffer in WR and is 0 otherwise.

**Completion signals**
- `done_o` is registered: high exactly one cycle, the cycle after the final LCAP, WR or ERR state.
- `err_o` is high only in that same cycle and only for ERR.

**Reset**
- `rst_i` forces IDLE immediately, asynchronously.
- `busy_o`, `done_o`, `err_o`, `rdata_o`, `mem_rd_o`, `mem_wr_o`, `mem_addr_o` and `mem_wdata_o` all go to 0.
- Reset during RD or MERGE aborts with no write. Reset during WR deasserts `mem_wr_o` before the next edge, so no write occurs.

## Timing

Request accepted at edge 0 (cycle 0 = IDLE with `req_i` high):

**Load**
- Cycle 1: RD, `mem_rd_o`=1.
- Cycle 2: LCAP, data valid.
- Cycle 3: `done_o`=1, `rdata_o` valid.
- Latency 3.

**SW**
- Cycle 1: WR.
- Cycle 2: `done_o`.
- Latency 2.

**SB/SH**
- Cycle 1: RD.
- Cycle 2: MERGE.
- Cycle 3: WR.
- Cycle 4: `done_o`.
- Latency 4.

**Error**
- Cycle 1: ERR.
- Cycle 2: `done_o` and `err_o`.

**Flow control**
- `busy_o` is high in cycles 1 through the final state and low in the `done_o` cycle.
- A new `req_i` is accepted in the `done_o` cycle, allowing back-to-back requests.
- `req_i` held high continuously issues a new access on every IDLE cycle.

## Test plan

1. **SW then LW.** SW addr 0x10, data 0xDEADBEEF → `mem_wr_o` in cycle 1 with `mem_addr_o`=4, `done_o` in cycle 2. Then LW 0x10 → `rdata_o`=0xDEADBEEF at cycle 3, `err_o`=0.
2. **Byte/halfword loads.** Memory word 4 = 0x80FF7F01.
   - LB 0x13 → 0xFFFFFF80.
   - LBU 0x13 → 0x00000080.
   - LH 0x12 → 0xFFFF80FF.
   - LHU 0x10 → 0x00007F01.
3. **Sub-word stores.** Word 4 = 0x11223344.
   - SB 0x11, data 0xAB → memory 0x1122AB44.
   - Then SH 0x12, data 0xCDEF → 0xCDEFAB44.
   - Each asserts `mem_rd_o` in cycle 1, `mem_wr_o` in cycle 3, `done_o` in cycle 4.
4. **Errors.** LW 0x12, SH 0x01, load funct3=011, and LW 0x400 (word 256, with `MEM_WORDS`=256) → `done_o`=`err_o`=1 in cycle 2. No strobes occur, memory is unchanged, and `rdata_o` keeps its prior value.
5. **Back-to-back and busy.** Hold `req_i` with alternating SW/LW to the same word → each accepted in the previous `done_o` cycle, with the load returning the just-stored value. Requests changed mid-busy are ignored.
6. **Reset mid-operation.** Assert `rst_i` during MERGE of an SB → all outputs 0 immediately, no `mem_wr_o`, the target word is unchanged. The next LW after release completes normally.
